// File: rtl/dac_dual_buffer.sv
// Ping-pong playback buffer: MCU fills the back buffer over the parallel bus,
// commits it, and the block loops the front buffer to the DAC one sample per
// dac_clk rising edge, swapping buffers only at a waveform period boundary.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   en                bus chip enable (qualifies addr_en / wr_en / rd_en)
//   addr_en           latch bus_din as the register/sample address
//   wr_en, rd_en      bus write / read strobes
//   bus_din           bus write data or address
//   bus_dout          registered bus read data (holds between reads)
//   dac_clk           sample-rate clock, synchronous to clk, period >= 4 clk
//   dac_data          registered sample to the DAC
//   playing           1 while the playback FSM is in PLAY
module dac_dual_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DAC_WIDTH  = 12,
    parameter int BUF_SIZE   = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  addr_en,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] bus_din,
    output logic [DATA_WIDTH-1:0] bus_dout,
    input  logic                  dac_clk,
    output logic [DAC_WIDTH-1:0]  dac_data,
    output logic                  playing
);

    localparam int AW = $clog2(BUF_SIZE);
    localparam int LW = $clog2(BUF_SIZE + 1);

    localparam logic [DATA_WIDTH-1:0] CTRL_ADDR = DATA_WIDTH'(16'h4000);
    localparam logic [DATA_WIDTH-1:0] LEN_ADDR  = DATA_WIDTH'(16'h4001);
    localparam logic [DATA_WIDTH-1:0] BUF_END   = DATA_WIDTH'(BUF_SIZE);
    localparam logic [LW-1:0]         LEN_MAX   = LW'(BUF_SIZE);
    localparam logic [DAC_WIDTH-1:0]  MIDSCALE  = DAC_WIDTH'(1) << (DAC_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SWAP = 2'd1,
        PLAY = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  front_sel_q, front_sel_d;
    logic                  fill_q, fill_d;
    logic                  pending_q, pending_d;
    logic [LW-1:0]         len_q, len_d;
    logic [LW-1:0]         pend_len_q, pend_len_d;
    logic [LW-1:0]         play_len_q, play_len_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DAC_WIDTH-1:0]  dac_data_q, dac_data_d;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] bus_dout_q;
    logic                  dac_clk_q;
    logic [DAC_WIDTH-1:0]  prefetch_q;

    logic [DAC_WIDTH-1:0]  ram [2*BUF_SIZE];

    logic                  bus_wr;
    logic                  bus_rd;
    logic                  hit_ram;
    logic                  hit_ctrl;
    logic                  hit_len;
    logic                  commit;
    logic                  can_swap;
    logic                  tick;
    logic                  wrap;
    logic [AW:0]           back_idx;
    logic [LW-1:0]         len_wdata;

    assign bus_wr   = en & wr_en;
    assign bus_rd   = en & rd_en;
    assign hit_ram  = addr_q < BUF_END;
    assign hit_ctrl = addr_q == CTRL_ADDR;
    assign hit_len  = addr_q == LEN_ADDR;
    assign back_idx = {~front_sel_q, addr_q[AW-1:0]};

    // Commit is the fill 1->0 transition caused by a CTRL write.
    assign commit   = bus_wr & hit_ctrl & fill_q & ~bus_din[0];
    assign can_swap = pending_q & ~fill_q;
    assign tick     = dac_clk & ~dac_clk_q;
    assign wrap     = LW'(rd_ptr_q) == play_len_q - LW'(1);

    assign len_wdata = (bus_din == '0 || bus_din > BUF_END)
                     ? LEN_MAX : bus_din[LW-1:0];

    assign bus_dout = bus_dout_q;
    assign dac_data = dac_data_q;
    assign playing  = state_q == PLAY;

    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        fill_d      = fill_q;
        pending_d   = pending_q;
        len_d       = len_q;
        pend_len_d  = pend_len_q;
        play_len_d  = play_len_q;
        rd_ptr_d    = rd_ptr_q;
        dac_data_d  = dac_data_q;

        if (bus_wr && hit_ctrl) fill_d = bus_din[0];
        if (bus_wr && hit_len)  len_d  = len_wdata;

        unique case (state_q)
            IDLE: begin
                if (can_swap) state_d = SWAP;
            end
            SWAP: begin
                front_sel_d = ~front_sel_q;
                play_len_d  = pend_len_q;
                rd_ptr_d    = '0;
                pending_d   = 1'b0;
                state_d     = PLAY;
            end
            PLAY: begin
                if (tick) begin
                    dac_data_d = prefetch_q;
                    if (!wrap)         rd_ptr_d = rd_ptr_q + AW'(1);
                    else if (can_swap) state_d  = SWAP;
                    else               rd_ptr_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A commit in the SWAP cycle re-arms pending for the next wrap.
        if (commit) begin
            pending_d  = 1'b1;
            pend_len_d = len_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            front_sel_q <= 1'b0;
            fill_q      <= 1'b0;
            pending_q   <= 1'b0;
            len_q       <= LEN_MAX;
            pend_len_q  <= LEN_MAX;
            play_len_q  <= LEN_MAX;
            rd_ptr_q    <= '0;
            dac_data_q  <= MIDSCALE;
            addr_q      <= '0;
            bus_dout_q  <= '1;
            dac_clk_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            fill_q      <= fill_d;
            pending_q   <= pending_d;
            len_q       <= len_d;
            pend_len_q  <= pend_len_d;
            play_len_q  <= play_len_d;
            rd_ptr_q    <= rd_ptr_d;
            dac_data_q  <= dac_data_d;
            dac_clk_q   <= dac_clk;
            if (en && addr_en) addr_q <= bus_din;
            if (bus_rd) begin
                if (hit_ram)
                    bus_dout_q <= DATA_WIDTH'(ram[back_idx]);
                else if (hit_ctrl)
                    bus_dout_q <= DATA_WIDTH'({playing, pending_q, fill_q});
                else if (hit_len)
                    bus_dout_q <= DATA_WIDTH'(len_q);
                else
                    bus_dout_q <= '1;
            end
        end
    end

    // Prefetch follows the next-state pointer so the word is ready on the
    // first PLAY cycle after a swap and one clk after every advance.
    always_ff @(posedge clk) begin
        if (bus_wr && hit_ram && fill_q)
            ram[back_idx] <= bus_din[DAC_WIDTH-1:0];
        prefetch_q <= ram[{front_sel_d, rd_ptr_d}];
    end

endmodule

// File: tb/tb_dac_dual_buffer.sv
// Directed self-checking bench for dac_dual_buffer.
// Inputs change on the falling clk edge; outputs are sampled there too.
module tb_dac_dual_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        addr_en = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] bus_din = '0;
    logic [15:0] bus_dout;
    logic        dac_clk = 1'b0;
    logic [11:0] dac_data;
    logic        playing;

    int checks = 0;
    int errors = 0;

    dac_dual_buffer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .addr_en  (addr_en),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .bus_din  (bus_din),
        .bus_dout (bus_dout),
        .dac_clk  (dac_clk),
        .dac_data (dac_data),
        .playing  (playing)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        en = 1'b1; addr_en = 1'b1; bus_din = a;
        @(negedge clk);
        addr_en = 1'b0; wr_en = 1'b1; bus_din = d;
        @(negedge clk);
        wr_en = 1'b0; en = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk);
        en = 1'b1; addr_en = 1'b1; bus_din = a;
        @(negedge clk);
        addr_en = 1'b0; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0; en = 1'b0;
        d = bus_dout;
    endtask

    task automatic dac_tick();
        @(negedge clk);
        dac_clk = 1'b1;
        repeat (4) @(negedge clk);
        dac_clk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic play_seq(input string tag, input logic [11:0] exp[$]);
        foreach (exp[i]) begin
            dac_tick();
            check($sformatf("%s[%0d]", tag, i), 32'(dac_data), 32'(exp[i]));
        end
    endtask

    logic [15:0] rd;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // T1 reset state
        check("rst_dout", 32'(bus_dout), 32'hFFFF);
        check("rst_dac", 32'(dac_data), 32'h800);
        check("rst_play", 32'(playing), 32'h0);
        bus_rd(16'h4000, rd);
        check("rst_ctrl", 32'(rd), 32'h0000);
        bus_rd(16'h4001, rd);
        check("rst_len", 32'(rd), 32'h0400);

        // T2 first buffer, 4 samples
        bus_wr(16'h4000, 16'h0001);
        bus_wr(16'h0000, 16'h0100);
        bus_wr(16'h0001, 16'h0200);
        bus_wr(16'h0002, 16'h0300);
        bus_wr(16'h0003, 16'h0400);
        bus_wr(16'h4001, 16'h0004);
        bus_wr(16'h4000, 16'h0000);
        repeat (3) @(negedge clk);
        check("t2_play", 32'(playing), 32'h1);
        play_seq("t2", '{12'h100, 12'h200, 12'h300, 12'h400, 12'h100,
                         12'h200, 12'h300, 12'h400, 12'h100, 12'h200});

        // T3 commit mid-period; swap waits for the wrap
        bus_wr(16'h4000, 16'h0001);
        bus_wr(16'h0000, 16'h0A00);
        bus_wr(16'h0001, 16'h0A01);
        bus_wr(16'h0002, 16'h0A02);
        bus_wr(16'h0003, 16'h0A03);
        bus_wr(16'h4001, 16'h0004);
        bus_wr(16'h4000, 16'h0000);
        bus_rd(16'h4000, rd);
        check("t3_pend", 32'(rd), 32'h0006);
        play_seq("t3", '{12'h300, 12'h400, 12'hA00, 12'hA01, 12'hA02,
                         12'hA03, 12'hA00});
        bus_rd(16'h4000, rd);
        check("t3_ctrl", 32'(rd), 32'h0004);

        // T4 commit, then refill before the wrap: no swap while fill=1
        bus_wr(16'h4000, 16'h0001);
        bus_wr(16'h0000, 16'h0B00);
        bus_wr(16'h0001, 16'h0B01);
        bus_wr(16'h0002, 16'h0B02);
        bus_wr(16'h0003, 16'h0B03);
        bus_wr(16'h4000, 16'h0000);
        bus_wr(16'h4000, 16'h0001);
        bus_rd(16'h4000, rd);
        check("t4_ctrl", 32'(rd), 32'h0007);
        play_seq("t4a", '{12'hA01, 12'hA02, 12'hA03, 12'hA00, 12'hA01,
                          12'hA02, 12'hA03});
        bus_wr(16'h4000, 16'h0000);
        play_seq("t4b", '{12'hA00, 12'hA01, 12'hA02, 12'hA03, 12'hB00,
                          12'hB01});

        // T5 dropped writes, LEN clamping, unmapped read
        bus_wr(16'h0000, 16'h0EEE);
        bus_rd(16'h0000, rd);
        check("t5_ram", 32'(rd), 32'h0A00);
        bus_wr(16'h4001, 16'h0000);
        bus_rd(16'h4001, rd);
        check("t5_len0", 32'(rd), 32'h0400);
        bus_wr(16'h4001, 16'd2000);
        bus_rd(16'h4001, rd);
        check("t5_len2k", 32'(rd), 32'h0400);
        bus_rd(16'h5000, rd);
        check("t5_unmap", 32'(rd), 32'hFFFF);

        // T6 async reset mid-play (rd_ptr=2), then replay with LEN=1
        check("t6_pre", 32'(dac_data), 32'hB01);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_dac", 32'(dac_data), 32'h800);
        check("t6_play", 32'(playing), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_rd(16'h4000, rd);
        check("t6_ctrl", 32'(rd), 32'h0000);
        dac_tick();
        check("t6_hold", 32'(dac_data), 32'h800);
        check("t6_idle", 32'(playing), 32'h0);
        bus_wr(16'h4000, 16'h0001);
        bus_wr(16'h0000, 16'h0123);
        bus_wr(16'h4001, 16'h0001);
        bus_wr(16'h4000, 16'h0000);
        repeat (3) @(negedge clk);
        check("t6_replay", 32'(playing), 32'h1);
        play_seq("t6", '{12'h123, 12'h123, 12'h123});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
